// File: rtl/ysyx_lsu_if.sv
// Bundle for the ysyx_lsu load/store unit: the execute-stage request and
// response channels plus the data-memory bus.
//   slave  : the LSU's view
//   master : the environment's view (execute stage and memory side)
interface ysyx_lsu_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   logic              mem_valid;
   logic              mem_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN/8-1:0] mem_wmask;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport slave (
      input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
      input  resp_ready, mem_ready, mem_rvalid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_wen, req_funct3, req_addr, req_wdata,
      output resp_ready, mem_ready, mem_rvalid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit with byte lanes, write masks,
// sign/zero extension and misalignment detection. One access in flight.
// Optional watchdog: define YSYX_LSU_TIMEOUT_EN to abort a bus access that
// has spent TIMEOUT_CYC cycles in BUS/WAIT.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for an access
//   BUS    | mem_valid high, waiting for mem_ready
//   WAIT   | request taken by memory, waiting for mem_rvalid
//   DONE   | resp_valid high, waiting for resp_ready
module ysyx_lsu #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic     clk,
   input  logic     rst,
   ysyx_lsu_if.slave bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              wen_q, wen_d;
   logic [2:0]        f3_q, f3_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
`ifdef YSYX_LSU_TIMEOUT_EN
   logic [31:0]       cnt_q, cnt_d;
`else
   // Without the watchdog the LSU waits indefinitely; TIMEOUT_CYC has no effect.
   if (TIMEOUT_CYC < 0) begin : g_timeout_ignored
   end
`endif

   logic              req_legal, req_misal;
   logic [OFF_W-1:0]  req_off;
   logic [NB-1:0]     req_ones;
   logic [ADDR_W-1:0] req_addr_al;
   logic [XLEN-1:0]   req_wdata_sh;
   logic [NB-1:0]     req_wmask;
   logic [XLEN-1:0]   ld_sh, ld_mask, ld_data;
   logic              ld_sign;

   assign req_off     = bus.req_addr[OFF_W-1:0];
   assign req_addr_al = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // Decode the incoming request: legality, alignment, lane mask and shifted store data.
   always_comb begin
      req_legal = 1'b0;
      if (bus.req_wen) begin
         req_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11 || XLEN == 64);
      end else begin
         case (bus.req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
            3'b011, 3'b110:                         req_legal = (XLEN == 64);
            default:                                req_legal = 1'b0;
         endcase
      end
      case (bus.req_funct3[1:0])
         2'd0:    begin req_misal = 1'b0;               req_ones = NB'(4'h1); end
         2'd1:    begin req_misal = bus.req_addr[0];    req_ones = NB'(4'h3); end
         2'd2:    begin req_misal = |bus.req_addr[1:0]; req_ones = NB'(4'hF); end
         default: begin req_misal = |bus.req_addr[2:0]; req_ones = '1;        end
      endcase
      req_wmask    = bus.req_wen ? (req_ones << req_off) : '0;
      req_wdata_sh = bus.req_wen ? (bus.req_wdata << {req_off, 3'b000}) : '0;
   end

   // Align the returned word to the access, truncate to size and extend.
   always_comb begin
      ld_sh = bus.mem_rdata >> {off_q, 3'b000};
      case (f3_q[1:0])
         2'd0:    ld_mask = XLEN'(8'hFF);
         2'd1:    ld_mask = XLEN'(16'hFFFF);
         2'd2:    ld_mask = XLEN'(32'hFFFF_FFFF);
         default: ld_mask = '1;
      endcase
      ld_sign = |(ld_sh & ld_mask & ~(ld_mask >> 1));
      ld_data = (!f3_q[2] && ld_sign) ? (ld_sh | ~ld_mask) : (ld_sh & ld_mask);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      wen_d        = wen_q;
      f3_d         = f3_q;
      off_d        = off_q;
      mem_valid_d  = mem_valid_q;
      mem_wen_d    = mem_wen_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
`ifdef YSYX_LSU_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               wen_d = bus.req_wen;
               f3_d  = bus.req_funct3;
               off_d = req_off;
               if (!req_legal || req_misal) begin
                  state_d      = S_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d     = S_BUS;
                  mem_valid_d = 1'b1;
                  mem_wen_d   = bus.req_wen;
                  mem_addr_d  = req_addr_al;
                  mem_wdata_d = req_wdata_sh;
                  mem_wmask_d = req_wmask;
               end
            end
         end
         S_BUS: begin
            if (bus.mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               state_d      = S_DONE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = wen_q ? '0 : ld_data;
            end
         end
         S_DONE: begin
            if (bus.resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef YSYX_LSU_TIMEOUT_EN
      // Watchdog overrides a completion landing on the same cycle as the limit.
      if (state_q == S_IDLE) begin
         cnt_d = '0;
      end else if (state_q == S_BUS || state_q == S_WAIT) begin
         if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            state_d      = S_DONE;
            mem_valid_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
`endif
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wen_q        <= 1'b0;
         f3_q         <= '0;
         off_q        <= '0;
         mem_valid_q  <= 1'b0;
         mem_wen_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
`ifdef YSYX_LSU_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wen_q        <= wen_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         mem_valid_q  <= mem_valid_d;
         mem_wen_q    <= mem_wen_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
`ifdef YSYX_LSU_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_wen    = mem_wen_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu (XLEN=32) with a byte-level reference model.
module tb_ysyx_lsu;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;
   localparam int NB     = XLEN / 8;
`ifdef YSYX_LSU_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   ysyx_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic        chk_en = 1'b0;
   logic        exp_bus_ok, exp_wen, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_mask;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Byte-level model of one access.
   function automatic void model(input logic wen, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, output logic err,
                                 output logic [31:0] maddr, output logic [31:0] mwd,
                                 output logic [3:0] mmask, output logic [31:0] res);
      int size, off;
      logic legal;
      logic [31:0] v;
      size = 1 << f3[1:0];
      off  = int'(addr % NB);
      if (wen) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (XLEN == 64 && f3 == 3'd3));
      else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                       (XLEN == 64 && (f3 == 3'd3 || f3 == 3'd6));
      err   = !legal || (addr % size != 0);
      maddr = addr - off;
      mwd   = '0;
      mmask = '0;
      res   = '0;
      if (wen && !err) begin
         for (int b = 0; b < NB; b++) begin
            if (b >= off && b < off + size) mmask[b] = 1'b1;
            if (b >= off) mwd[8*b +: 8] = wd[8*(b-off) +: 8];
         end
      end
      if (!wen && !err) begin
         v = '0;
         for (int i = 0; i < size; i++)
            if (off + i < NB) v[8*i +: 8] = rd[8*(off+i) +: 8];
         if (!f3[2] && v[8*size-1])
            for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
         res = v;
      end
   endfunction

   // Compare DUT outputs against the model whenever they carry meaning.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (bus.mem_valid) begin
            chk("mem_valid_on_err", {63'd0, bus.mem_valid & ~exp_bus_ok}, 64'd0);
            if (exp_bus_ok) begin
               chk("mem_wen",   {63'd0, bus.mem_wen}, {63'd0, exp_wen});
               chk("mem_addr",  {32'd0, bus.mem_addr}, {32'd0, exp_addr});
               chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, exp_wdata});
               chk("mem_wmask", {60'd0, bus.mem_wmask}, {60'd0, exp_mask});
            end
         end
         if (bus.resp_valid) begin
            chk("resp_err",   {63'd0, bus.resp_err}, {63'd0, exp_err});
            chk("resp_rdata", {32'd0, bus.resp_rdata}, {32'd0, exp_rdata});
         end
      end
   end

   task automatic set_exp(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
      model(wen, f3, addr, wd, rd, exp_err, exp_addr, exp_wdata, exp_mask, exp_rdata);
      exp_wen    = wen;
      exp_bus_ok = !exp_err;
   endtask

   task automatic present(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      bus.req_valid  = 1'b1;
      bus.req_wen    = wen;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
   endtask

   task automatic do_access(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int rdy_dly, input int rv_dly, input int rr_dly,
                            input logic [31:0] lit_rdata, input logic lit_err);
      set_exp(wen, f3, addr, wd, rd);
      chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
      present(wen, f3, addr, wd);
      if (exp_err) begin
         chk("err_resp_c1", {63'd0, bus.resp_valid}, 64'd1);
         chk("err_no_bus",  {63'd0, bus.mem_valid}, 64'd0);
      end else begin
         chk("mem_valid_c1", {63'd0, bus.mem_valid}, 64'd1);
         chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
         repeat (rdy_dly) begin
            @(posedge clk); #1;
            chk("mem_valid_held", {63'd0, bus.mem_valid}, 64'd1);
            chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
         end
         bus.mem_ready = 1'b1;
         @(posedge clk); #1;
         bus.mem_ready = 1'b0;
         chk("mem_valid_drop", {63'd0, bus.mem_valid}, 64'd0);
         chk("resp_not_early", {63'd0, bus.resp_valid}, 64'd0);
         repeat (rv_dly) begin
            @(posedge clk); #1;
            chk("wait_no_resp", {63'd0, bus.resp_valid}, 64'd0);
            chk("wait_no_bus",  {63'd0, bus.mem_valid}, 64'd0);
         end
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = rd;
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = 32'h5A5A_5A5A;
         chk("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      end
      chk("lit_rdata", {32'd0, bus.resp_rdata}, {32'd0, lit_rdata});
      chk("lit_err",   {63'd0, bus.resp_err}, {63'd0, lit_err});
      repeat (rr_dly) begin
         @(posedge clk); #1;
         chk("resp_held", {63'd0, bus.resp_valid}, 64'd1);
         chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk("resp_cleared",     {63'd0, bus.resp_valid}, 64'd0);
      chk("resp_err_cleared", {63'd0, bus.resp_err}, 64'd0);
      chk("req_ready_back",   {63'd0, bus.req_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        m_err;
      logic [31:0] m_addr, m_wd, m_res;
      logic [3:0]  m_mask;

      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      exp_bus_ok = 1'b0; exp_wen = 1'b0; exp_err = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_mask = '0;

      // Pin the model with hand-computed values.
      model(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, m_err, m_addr, m_wd, m_mask, m_res);
      chk("model_lb_rdata", {32'd0, m_res}, 64'hFFFF_FF80);
      chk("model_lb_addr",  {32'd0, m_addr}, 64'h8000_0000);
      chk("model_lb_mask",  {60'd0, m_mask}, 64'h0);
      model(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, m_err, m_addr, m_wd, m_mask, m_res);
      chk("model_sh_wdata", {32'd0, m_wd}, 64'hABCD_0000);
      chk("model_sh_mask",  {60'd0, m_mask}, 64'hC);
      chk("model_sh_err",   {63'd0, m_err}, 64'd0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_valid",  {63'd0, bus.mem_valid}, 64'd0);
      chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_resp_err",   {63'd0, bus.resp_err}, 64'd0);
      chk("rst_mem_wmask",  {60'd0, bus.mem_wmask}, 64'd0);
      chk("rst_mem_addr",   {32'd0, bus.mem_addr}, 64'd0);
      chk("rst_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

      // wen f3 addr wdata rdata rdy rv rr lit_rdata lit_err
      do_access(1'b0, 3'b000, 32'h8000_0003, 32'h0,         32'h80FF_1234, 0, 0, 0, 32'hFFFF_FF80, 1'b0);
      do_access(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0,         0, 0, 0, 32'h0,         1'b0);
      do_access(1'b0, 3'b010, 32'h8000_0001, 32'h0,         32'h0,         0, 0, 0, 32'h0,         1'b1);
      do_access(1'b0, 3'b111, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 1, 32'h0,         1'b1);
      do_access(1'b0, 3'b100, 32'h8000_0001, 32'h0,         32'h80FF_1234, 0, 1, 0, 32'h0000_0012, 1'b0);
      do_access(1'b0, 3'b001, 32'h8000_0002, 32'h0,         32'h80FF_1234, 1, 0, 0, 32'hFFFF_80FF, 1'b0);
      do_access(1'b0, 3'b010, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      do_access(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'h0,         0, 0, 0, 32'h0,         1'b0);
      do_access(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,         0, 2, 0, 32'h0,         1'b0);
      do_access(1'b1, 3'b011, 32'h8000_0000, 32'h1111_1111, 32'h0,         0, 0, 0, 32'h0,         1'b1);
      do_access(1'b0, 3'b101, 32'h8000_0003, 32'h0,         32'h0,         0, 0, 0, 32'h0,         1'b1);
      do_access(1'b0, 3'b110, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 0, 32'h0,         1'b1);
      // Backpressure on both sides.
      do_access(1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'h1357_9BDF, 5, 2, 3, 32'h1357_9BDF, 1'b0);

      // Reset while in BUS drops mem_valid.
      set_exp(1'b0, 3'b010, 32'h8000_0030, 32'h0, 32'h0);
      present(1'b0, 3'b010, 32'h8000_0030, 32'h0);
      chk("bus_before_rst", {63'd0, bus.mem_valid}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_bus_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
      chk("rst_bus_req_ready", {63'd0, bus.req_ready}, 64'd1);

      // Reset while in WAIT, then a stale rvalid.
      set_exp(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0);
      present(1'b0, 3'b010, 32'h8000_0020, 32'h0);
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      chk("wait_before_rst", {63'd0, bus.mem_valid}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_wait_req_ready",  {63'd0, bus.req_ready}, 64'd1);
      chk("rst_wait_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      repeat (2) begin
         chk("stale_rvalid_no_resp", {63'd0, bus.resp_valid}, 64'd0);
         chk("stale_rvalid_idle",    {63'd0, bus.req_ready}, 64'd1);
         @(posedge clk); #1;
      end
      do_access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0, 0, 32'h0000_8001, 1'b0);

`ifdef YSYX_LSU_TIMEOUT_EN
      // Watchdog: mem_ready never arrives.
      set_exp(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0);
      present(1'b0, 3'b010, 32'h8000_0040, 32'h0);
      for (int i = 0; i < TO - 1; i++) begin
         chk("to_mem_valid_held", {63'd0, bus.mem_valid}, 64'd1);
         @(posedge clk); #1;
      end
      chk("to_mem_valid_last", {63'd0, bus.mem_valid}, 64'd1);
      chk("to_no_resp_yet",    {63'd0, bus.resp_valid}, 64'd0);
      exp_err   = 1'b1;
      exp_rdata = '0;
      @(posedge clk); #1;
      chk("to_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("to_resp_err",   {63'd0, bus.resp_err}, 64'd1);
      chk("to_mem_valid",  {63'd0, bus.mem_valid}, 64'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777_7777;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      chk("to_stale_err",   {63'd0, bus.resp_err}, 64'd1);
      chk("to_stale_rdata", {32'd0, bus.resp_rdata}, 64'd0);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk("to_back_idle", {63'd0, bus.req_ready}, 64'd1);
      bus.mem_rvalid = 1'b1;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      chk("to_idle_rvalid_ignored", {63'd0, bus.resp_valid}, 64'd0);
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/ysyx_lsu.md
Name: ysyx_lsu

Overview:
- Parametrised multi-cycle load/store unit; successor to the execute stage's single-cycle, word-only, zero-latency memory access.
- Sits between the execute stage (request/response valid-ready) and the data memory bus (valid/ready request, rvalid response).
- Handles byte/half/word (and double when XLEN=64) accesses with byte lanes, write masks, sign/zero extension and misalignment detection.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU accepts an access (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  result available
- resp_ready  in  1  execute stage takes result
- resp_rdata  out  XLEN  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or illegal access
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_wen  out  1  bus write
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  XLEN/8  byte write mask (0 for loads)
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  XLEN  full-width read word

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; mem_valid, mem_wen, resp_valid and resp_err are 0; mem_wmask, mem_addr, mem_wdata and resp_rdata are 0. All outputs are registered except req_ready (equals state==IDLE).
- Reset mid-operation: return to IDLE the next edge and drop mem_valid. An mem_rvalid arriving while in IDLE is ignored.
- Legal funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; if XLEN=64, also 011 LD and 110 LWU.
- Legal funct3, stores: 000, 001 and 010; if XLEN=64, also 011.
- Any other code is illegal.
- Misaligned: addr not a multiple of the access size.
- Byte offset: off = addr mod (XLEN/8).
- mem_wmask = size ones shifted left by off.
- mem_wdata = req_wdata shifted left by 8*off.
- Load data = mem_rdata shifted right by 8*off, truncated to size, then sign-extended (LB/LH/LW) or zero-extended (others) to XLEN.
- State IDLE: on req_valid, latch the request. Illegal or misaligned requests go to DONE with resp_err=1 and resp_rdata=0; there is no bus activity. Otherwise go to BUS.
- State BUS: mem_valid=1 with address, data and mask stable until mem_ready. On mem_valid&&mem_ready, move to WAIT and deassert mem_valid.
- State WAIT: on mem_rvalid (stores receive it as the write ack), capture the extended data (loads) or 0 (stores) and go to DONE.
- State DONE: resp_valid=1 and outputs stable until resp_ready. On resp_ready, go to IDLE and clear resp_valid/resp_err.
- Minimum latency: accept at cycle 0; mem_valid at 1; with ready at 1 and rvalid at 2, resp_valid at 3. Error path: resp_valid at 1.
- One outstanding access only. No new accept until the DONE handshake completes, so back-to-back accepts are at least 4 cycles apart.

Optional Feature:
- Macro: YSYX_LSU_TIMEOUT_EN.
- With the macro defined: a counter is cleared on entering BUS and increments each cycle in BUS or WAIT. When it reaches TIMEOUT_CYC, abort to DONE with resp_err=1 and resp_rdata=0, and drop mem_valid. A later stale mem_rvalid is ignored.
- Without the macro: the LSU waits indefinitely and TIMEOUT_CYC is unused.

Test Plan:
- LB: addr 0x8000_0003, mem_rdata 0x80FF_1234 -> mem_addr 0x8000_0000, mask 0000, resp_rdata 0xFFFF_FF80, err 0.
- SH: addr 0x8000_0002, wdata 0x0000_ABCD -> mem_wdata 0xABCD_0000, mem_wmask 1100, resp_rdata 0 after rvalid.
- LW at 0x8000_0001 -> resp_valid the cycle after accept, resp_err 1, mem_valid never asserted. Illegal funct3 111 gives the same response.
- Backpressure: mem_ready held low 5 cycles, resp_ready low 3 cycles -> mem_* stable throughout, resp held, req_ready 0 until the resp handshake.
- rst asserted while in WAIT, then mem_rvalid pulses -> IDLE next edge, no resp_valid, next LHU at 0x8000_0002 with rdata 0x8001_0000 returns 0x0000_8001.
- YSYX_LSU_TIMEOUT_EN with TIMEOUT_CYC=8, mem_ready stuck 0 -> resp_err 1 and mem_valid 0 after 8 cycles in BUS.
